// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared Viterbi survivor-memory constants, types and FSM encoding
package viterbi_pkg;
  localparam int SPM_K = 3;
  localparam int SPM_METRIC_W = 8;
  localparam int SPM_MAX_FRAME = 256;
  localparam int NUM_STATES = 2 ** (SPM_K - 1);
  localparam int LEN_W = $clog2(SPM_MAX_FRAME + 1);
  typedef logic [SPM_K-2:0] state_t;
  typedef logic [SPM_METRIC_W-1:0] metric_t;
  typedef enum logic [2:0] {IDLE, WRITE, SELECT, TRACE, OUT, DONE} spm_state_e;
endpackage

// File: rtl/spm_argmin.sv
// spm_argmin: combinational minimum-metric index search, lowest index wins ties
module spm_argmin
  import viterbi_pkg::*;
#(
  parameter int N = NUM_STATES,
  parameter int W = SPM_METRIC_W,
  localparam int IW = $clog2(N)
) (
  input  logic [N*W-1:0] metrics,
  output logic [IW-1:0]  idx
);
  logic [W-1:0] m;
  always_comb begin
    idx = '0;
    m = metrics[W-1:0];
    for (int i = 1; i < N; i++)
      if (metrics[i*W +: W] < m) begin
        m = metrics[i*W +: W];
        idx = IW'(i);
      end
  end
endmodule

// File: rtl/survivor_traceback_mem.sv
// survivor_traceback_mem: frame survivor memory with traceback and in-order bit output
// SPM_TERMINATED_EN: zero-tail frames, traceback always starts at state 0
module survivor_traceback_mem
  import viterbi_pkg::*;
#(
  parameter int K = SPM_K,
  parameter int METRIC_W = SPM_METRIC_W,
  parameter int MAX_FRAME = SPM_MAX_FRAME,
  localparam int NS = 2 ** (K - 1),
  localparam int LW = $clog2(MAX_FRAME + 1),
  localparam int AW = $clog2(MAX_FRAME)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [LW-1:0]          i_frame_len,
  input  logic                   i_dec_valid,
  output logic                   o_dec_ready,
  input  logic [NS-1:0]          i_dec,
  input  logic [NS*METRIC_W-1:0] i_path_metric,
  output logic                   o_bit,
  output logic                   o_bit_valid,
  input  logic                   i_bit_ready,
  output logic                   o_busy,
  output logic                   o_done
);
  spm_state_e state;
  logic [LW-1:0] len, wcnt, t, rcnt;
  logic [K-2:0] cur, best;
  logic [NS-1:0] col_q;
  logic [NS-1:0] dec_mem [MAX_FRAME];
  logic bit_mem [MAX_FRAME];
  logic [AW-1:0] raddr;
  logic last_w, last_r;
  assign last_w = wcnt == len - LW'(1);
  assign last_r = rcnt == len - LW'(1);
  // column for step t is fetched one cycle ahead so each TRACE cycle retires one step
  assign raddr = AW'(state == SELECT ? len - LW'(1) : t - LW'(1));
  assign o_dec_ready = state == WRITE;
  assign o_bit_valid = state == OUT;
  assign o_busy = state != IDLE;
  assign o_done = state == DONE;
`ifdef SPM_TERMINATED_EN
  assign best = '0;
`else
  logic [NS*METRIC_W-1:0] metrics;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) metrics <= '0;
    else if (state == WRITE && i_dec_valid && last_w) metrics <= i_path_metric;
  spm_argmin #(.N(NS), .W(METRIC_W)) u_argmin (.metrics(metrics), .idx(best));
`endif
  always_ff @(posedge i_clk) begin
    if (state == WRITE && i_dec_valid) dec_mem[AW'(wcnt)] <= i_dec;
    if (state == TRACE) bit_mem[AW'(t)] <= cur[K-2];
    col_q <= dec_mem[raddr];
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      len <= '0;
      wcnt <= '0;
      t <= '0;
      rcnt <= '0;
      cur <= '0;
      o_bit <= 1'b0;
    end else
      case (state)
        IDLE:
          if (i_start) begin
            len <= i_frame_len > LW'(MAX_FRAME) ? LW'(MAX_FRAME) : i_frame_len;
            wcnt <= '0;
            state <= i_frame_len == '0 ? DONE : WRITE;
          end
        WRITE:
          if (i_dec_valid) begin
            wcnt <= wcnt + LW'(1);
            if (last_w) state <= SELECT;
          end
        SELECT: begin
          cur <= best;
          t <= len - LW'(1);
          state <= TRACE;
        end
        TRACE: begin
          cur <= {cur[K-3:0], col_q[cur]};
          t <= t - LW'(1);
          o_bit <= cur[K-2];
          if (t == '0) begin
            rcnt <= '0;
            state <= OUT;
          end
        end
        OUT:
          if (i_bit_ready) begin
            rcnt <= rcnt + LW'(1);
            o_bit <= last_r ? 1'b0 : bit_mem[AW'(rcnt + LW'(1))];
            if (last_r) state <= DONE;
          end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule
